// File: rtl/fpu_exception_pipe_if.sv
// rtl/fpu_exception_pipe_if.sv - operand/result handshake bundle for the FPU exception pipe
interface fpu_exception_pipe_if #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int CNT_W = 8
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic             exc;
  logic [4:0]       flags;
  logic [4:0]       sticky;
  logic             sticky_clr;
  logic [CNT_W-1:0] exc_count;

  modport master (
    output in_valid, op, a, b, out_ready, sticky_clr,
    input  in_ready, out_valid, exc, flags, sticky, exc_count
  );

  modport slave (
    input  in_valid, op, a, b, out_ready, sticky_clr,
    output in_ready, out_valid, exc, flags, sticky, exc_count
  );
endinterface

// File: rtl/fpu_exception_pipe.sv
// rtl/fpu_exception_pipe.sv - registered NV/DZ exception detector with sticky flags and saturating counter
// Optional denormal flag (flags[4]) enabled by defining FPU_EXC_DENORM_EN.
module fpu_exception_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  fpu_exception_pipe_if.slave  bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  logic             out_valid_q, out_valid_d;
  logic             exc_q, exc_d;
  logic [4:0]       flags_q, flags_d;
  logic [4:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] exc_count_q, exc_count_d;

  logic a_sign, b_sign;
  logic a_exp_ones, b_exp_ones, a_exp_zero, b_exp_zero, a_man_nz, b_man_nz;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic nv_c, dz_c, ii_c, zi_c, dn_c;
  logic [4:0] new_flags;
  logic accept;

  assign a_sign     = bus.a[W-1];
  assign b_sign     = bus.b[W-1];
  assign a_exp_ones = &bus.a[W-2:MAN_W];
  assign b_exp_ones = &bus.b[W-2:MAN_W];
  assign a_exp_zero = ~|bus.a[W-2:MAN_W];
  assign b_exp_zero = ~|bus.b[W-2:MAN_W];
  assign a_man_nz   = |bus.a[MAN_W-1:0];
  assign b_man_nz   = |bus.b[MAN_W-1:0];

  assign a_nan  = a_exp_ones & a_man_nz;
  assign b_nan  = b_exp_ones & b_man_nz;
  assign a_inf  = a_exp_ones & ~a_man_nz;
  assign b_inf  = b_exp_ones & ~b_man_nz;
  assign a_zero = a_exp_zero & ~a_man_nz;
  assign b_zero = b_exp_zero & ~b_man_nz;

  always_comb begin
    nv_c = a_nan | b_nan;
    case (bus.op)
      OP_ADD:  nv_c = nv_c | (a_inf & b_inf & (a_sign ^ b_sign));
      OP_SUB:  nv_c = nv_c | (a_inf & b_inf & ~(a_sign ^ b_sign));
      OP_MUL:  nv_c = nv_c | (a_inf & b_zero) | (a_zero & b_inf);
      default: nv_c = nv_c | (a_zero & b_zero) | (a_inf & b_inf);
    endcase
  end

  // A denormal dividend is nonzero, so it still raises divide-by-zero.
  assign dz_c = (bus.op == OP_DIV) & b_zero & ~a_nan & ~a_inf & ~a_zero & ~nv_c;
  assign ii_c = a_inf | b_inf;
  assign zi_c = a_zero | b_zero;

`ifdef FPU_EXC_DENORM_EN
  assign dn_c = (a_exp_zero & a_man_nz) | (b_exp_zero & b_man_nz);
`else
  assign dn_c = 1'b0;
`endif

  assign new_flags = {dn_c, zi_c, ii_c, dz_c, nv_c};

  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  // sticky_clr zeroes the accumulators first, so a same-cycle accept lands on a clean slate.
  always_comb begin
    out_valid_d = out_valid_q;
    exc_d       = exc_q;
    flags_d     = flags_q;
    sticky_d    = bus.sticky_clr ? 5'd0 : sticky_q;
    exc_count_d = bus.sticky_clr ? '0 : exc_count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      flags_d     = new_flags;
      exc_d       = nv_c | dz_c;
      sticky_d    = sticky_d | new_flags;
      if ((nv_c | dz_c) && exc_count_d != CNT_MAX) begin
        exc_count_d = exc_count_d + 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      exc_q       <= 1'b0;
      flags_q     <= 5'd0;
      sticky_q    <= 5'd0;
      exc_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      exc_q       <= exc_d;
      flags_q     <= flags_d;
      sticky_q    <= sticky_d;
      exc_count_q <= exc_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.exc       = exc_q;
  assign bus.flags     = flags_q;
  assign bus.sticky    = sticky_q;
  assign bus.exc_count = exc_count_q;

endmodule

// File: tb/tb_fpu_exception_pipe.sv
// tb/tb_fpu_exception_pipe.sv - randomized self-checking bench for fpu_exception_pipe
module tb_fpu_exception_pipe;
  localparam int EXP_W   = 4;
  localparam int MAN_W   = 3;
  localparam int CNT_W   = 2;
  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_exception_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) bus_if ();

  fpu_exception_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit       m_ov;
  bit       m_exc;
  bit [4:0] m_flags;
  bit [4:0] m_sticky;
  int       m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 0 normal, 1 zero, 2 denormal, 3 inf, 4 nan
  function automatic int fclass(input int x);
    int e, m;
    e = (x >> MAN_W) % (1 << EXP_W);
    m = x % (1 << MAN_W);
    if (e == (1 << EXP_W) - 1) return (m != 0) ? 4 : 3;
    if (e == 0) return (m == 0) ? 1 : 2;
    return 0;
  endfunction

  function automatic bit [4:0] ref_flags(input int op, input int a, input int b);
    int ca, cb;
    bit sa, sb, nv, dz, ii, zi, dn;
    ca = fclass(a);
    cb = fclass(b);
    sa = (a / (1 << (W - 1))) != 0;
    sb = (b / (1 << (W - 1))) != 0;
    nv = (ca == 4) || (cb == 4);
    if (op == 0 && ca == 3 && cb == 3 && sa != sb) nv = 1;
    if (op == 1 && ca == 3 && cb == 3 && sa == sb) nv = 1;
    if (op == 2 && ((ca == 3 && cb == 1) || (ca == 1 && cb == 3))) nv = 1;
    if (op == 3 && ((ca == 1 && cb == 1) || (ca == 3 && cb == 3))) nv = 1;
    dz = (op == 3) && (cb == 1) && (ca == 0 || ca == 2) && !nv;
    ii = (ca == 3) || (cb == 3);
    zi = (ca == 1) || (cb == 1);
    dn = 0;
`ifdef FPU_EXC_DENORM_EN
    dn = (ca == 2) || (cb == 2);
`endif
    return {dn, zi, ii, dz, nv};
  endfunction

  task automatic model_reset();
    m_ov = 0; m_exc = 0; m_flags = 0; m_sticky = 0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".out_valid"}, bus_if.out_valid, m_ov);
    check_eq({tag, ".exc"}, bus_if.exc, m_exc);
    check_eq({tag, ".flags"}, bus_if.flags, m_flags);
    check_eq({tag, ".sticky"}, bus_if.sticky, m_sticky);
    check_eq({tag, ".exc_count"}, bus_if.exc_count, m_cnt);
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic cycle(input bit v, input int op, input int a, input int b,
                       input bit ordy, input bit clr, input string tag);
    bit acc;
    bit [4:0] f;
    bus_if.in_valid   = v;
    bus_if.op         = op[1:0];
    bus_if.a          = a[W-1:0];
    bus_if.b          = b[W-1:0];
    bus_if.out_ready  = ordy;
    bus_if.sticky_clr = clr;
    #1;
    check_eq({tag, ".in_ready"}, bus_if.in_ready, !m_ov || ordy);
    acc = v && (!m_ov || ordy);
    f = ref_flags(op, a % 256, b % 256);
    @(posedge clk);
    #1;
    if (clr) begin
      m_sticky = 0;
      m_cnt = 0;
    end
    if (acc) begin
      m_ov = 1;
      m_flags = f;
      m_exc = f[0] | f[1];
      m_sticky = m_sticky | f;
      if (m_exc && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (ordy) begin
      m_ov = 0;
    end
    check_outputs(tag);
  endtask

  typedef struct {
    int op;
    int a;
    int b;
    bit [3:0] f4;
    bit dn;
  } dir_t;

  dir_t dir_tab[8] = '{
    '{0, 'h79, 'h00, 4'b1001, 1'b0},
    '{0, 'h78, 'hF8, 4'b0101, 1'b0},
    '{1, 'h78, 'h78, 4'b0101, 1'b0},
    '{0, 'h78, 'h78, 4'b0100, 1'b0},
    '{2, 'h78, 'h00, 4'b1101, 1'b0},
    '{3, 'h38, 'h00, 4'b1010, 1'b0},
    '{3, 'h00, 'h00, 4'b1001, 1'b0},
    '{3, 'h01, 'h00, 4'b1010, 1'b1}
  };

  int pool[10] = '{'h00, 'h80, 'h01, 'h38, 'hB8, 'h78, 'hF8, 'h79, 'hFF, 'h07};

  function automatic int pick_operand();
    int k;
    k = $urandom_range(0, 11);
    if (k >= 10) return $urandom_range(0, 255);
    return pool[k];
  endfunction

  initial begin
    bit exp_dn;
    int cnt_seq[5] = '{1, 2, 3, 3, 3};

    bus_if.in_valid = 0; bus_if.op = 0; bus_if.a = 0; bus_if.b = 0;
    bus_if.out_ready = 0; bus_if.sticky_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.in_ready", bus_if.in_ready, 1);
    check_outputs("reset");
    rst_n = 1;

    foreach (dir_tab[i]) begin
      exp_dn = 0;
`ifdef FPU_EXC_DENORM_EN
      exp_dn = dir_tab[i].dn;
`endif
      cycle(1, dir_tab[i].op, dir_tab[i].a, dir_tab[i].b, 1, 0, $sformatf("dir%0d", i));
      check_eq($sformatf("dir%0d.flags_const", i), bus_if.flags, {exp_dn, dir_tab[i].f4});
      if (i == 0) check_eq("dir0.count_const", bus_if.exc_count, 1);
    end

    cycle(0, 0, 0, 0, 1, 0, "drain");
    cycle(1, 0, 'h38, 'h78, 0, 0, "bp_first");
    for (int i = 0; i < 3; i++) begin
      cycle(1, 2, 'h78, 'h00, 0, 0, "bp_hold");
      check_eq("bp_hold.in_ready_const", bus_if.in_ready, 0);
      check_eq("bp_hold.flags_const", bus_if.flags, 5'b00100);
    end
    cycle(1, 2, 'h78, 'h00, 1, 0, "bp_release");
    check_eq("bp_release.flags_const", bus_if.flags, 5'b01101);

    cycle(0, 0, 0, 0, 1, 1, "cnt_clr");
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 'h79, 'h38, 1, 0, "cnt_sat");
      check_eq($sformatf("cnt_sat%0d_const", i), bus_if.exc_count, cnt_seq[i]);
    end
    cycle(1, 3, 'h38, 'h00, 1, 1, "clr_accept");
    check_eq("clr_accept.count_const", bus_if.exc_count, 1);
    check_eq("clr_accept.sticky_const", bus_if.sticky, 5'b01010);

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), pick_operand(), pick_operand(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, "rand");
    end

    cycle(1, 0, 'h79, 'h00, 0, 0, "pre_rst");
    cycle(1, 0, 'h79, 'h00, 0, 0, "pre_rst");
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_eq("mid_rst.in_ready", bus_if.in_ready, 1);
    check_outputs("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 40; i++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, 3), pick_operand(), pick_operand(),
            $urandom_range(0, 1), 0, "post_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
